// File: rtl/occupancy_counter_if.sv
// Event inputs and registered status outputs of the parking-lot occupancy counter.
interface occupancy_counter_if;
  logic       car_enter;
  logic       car_exit;
  logic       clr;
  logic [6:0] count;
  logic [6:0] spaces;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       full;
  logic       empty;
  logic       err_over;
  logic       err_under;

  modport master (
    output car_enter, car_exit, clr,
    input  count, spaces, bcd_tens, bcd_ones, full, empty, err_over, err_under
  );

  modport slave (
    input  car_enter, car_exit, clr,
    output count, spaces, bcd_tens, bcd_ones, full, empty, err_over, err_under
  );
endinterface

// File: rtl/occupancy_counter.sv
// Saturating parking-lot occupancy counter driven by edge-detected enter/exit pulses.
// Every output is registered and derived from the same next-count value.
module occupancy_counter #(
  parameter int unsigned CAPACITY = 99
) (
  input logic                clk,
  input logic                reset_n,
  occupancy_counter_if.slave bus
);

  localparam logic [6:0] Cap = 7'(CAPACITY);

  if (CAPACITY < 1 || CAPACITY > 99) begin : g_cap_check
    $error("occupancy_counter: CAPACITY must be in 1..99");
  end

  logic       enter_d, exit_d;
  logic       ev_in, ev_out;
  logic [6:0] count_q, count_next;
  logic [6:0] spaces_q;
  logic [3:0] tens_q, ones_q, tens_next, ones_next;
  logic       full_q, empty_q;
  logic       err_over_q, err_over_next;
  logic       err_under_q, err_under_next;
  logic [6:0] rem;

  assign ev_in  = bus.car_enter & ~enter_d;
  assign ev_out = bus.car_exit & ~exit_d;

  always_comb begin
    count_next     = count_q;
    err_over_next  = err_over_q;
    err_under_next = err_under_q;
    if (bus.clr) begin
      count_next     = 7'd0;
      err_over_next  = 1'b0;
      err_under_next = 1'b0;
    end else if (ev_in && ev_out) begin
      // Simultaneous entry and exit cancel out, even at the bounds.
      count_next = count_q;
    end else if (ev_in) begin
      if (count_q == Cap) begin
        err_over_next = 1'b1;
      end else begin
        count_next = count_q + 7'd1;
      end
    end else if (ev_out) begin
      if (count_q == 7'd0) begin
        err_under_next = 1'b1;
      end else begin
        count_next = count_q - 7'd1;
      end
    end
  end

  // Repeated subtraction; nine steps cover the whole 0..99 range.
  always_comb begin
    tens_next = 4'd0;
    rem       = count_next;
    for (int i = 0; i < 9; i++) begin
      if (rem >= 7'd10) begin
        rem       = rem - 7'd10;
        tens_next = tens_next + 4'd1;
      end
    end
    ones_next = rem[3:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enter_d     <= 1'b0;
      exit_d      <= 1'b0;
      count_q     <= 7'd0;
      spaces_q    <= Cap;
      tens_q      <= 4'd0;
      ones_q      <= 4'd0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      err_over_q  <= 1'b0;
      err_under_q <= 1'b0;
    end else begin
      // History is kept across clr so a held input cannot retrigger.
      enter_d     <= bus.car_enter;
      exit_d      <= bus.car_exit;
      count_q     <= count_next;
      spaces_q    <= Cap - count_next;
      tens_q      <= tens_next;
      ones_q      <= ones_next;
      full_q      <= (count_next == Cap);
      empty_q     <= (count_next == 7'd0);
      err_over_q  <= err_over_next;
      err_under_q <= err_under_next;
    end
  end

  assign bus.count     = count_q;
  assign bus.spaces    = spaces_q;
  assign bus.bcd_tens  = tens_q;
  assign bus.bcd_ones  = ones_q;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.err_over  = err_over_q;
  assign bus.err_under = err_under_q;

endmodule

// File: tb/tb_occupancy_counter.sv
// Directed bench for occupancy_counter: a CAPACITY=99 instance and a CAPACITY=5 instance.
module tb_occupancy_counter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  occupancy_counter_if b0 ();
  occupancy_counter_if b1 ();

  occupancy_counter #(.CAPACITY(99)) u_dut0 (.clk(clk), .reset_n(reset_n), .bus(b0));
  occupancy_counter #(.CAPACITY(5))  u_dut1 (.clk(clk), .reset_n(reset_n), .bus(b1));

  // One-cycle pulse on the 99-car instance, followed by one idle cycle; returns #1 after each edge.
  task automatic pulse0(input logic en, input logic ex, input logic cl);
    @(negedge clk);
    b0.car_enter = en; b0.car_exit = ex; b0.clr = cl;
    @(posedge clk); #1;
    @(negedge clk);
    b0.car_enter = 1'b0; b0.car_exit = 1'b0; b0.clr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse1(input logic en, input logic ex);
    @(negedge clk);
    b1.car_enter = en; b1.car_exit = ex;
    @(posedge clk); #1;
    @(negedge clk);
    b1.car_enter = 1'b0; b1.car_exit = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    total++; if (b0.count !== 7'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", b0.count); end
    total++; if (b0.spaces !== 7'd99) begin bad++; $display("FAIL reset_spaces got=%0d exp=99", b0.spaces); end
    total++; if (b0.empty !== 1'b1 || b0.full !== 1'b0) begin bad++; $display("FAIL reset_flags got empty=%b full=%b exp 1/0", b0.empty, b0.full); end
    total++; if ({b0.bcd_tens, b0.bcd_ones} !== 8'h00) begin bad++; $display("FAIL reset_bcd got=%0d/%0d exp=0/0", b0.bcd_tens, b0.bcd_ones); end
    total++; if (b0.err_over !== 1'b0 || b0.err_under !== 1'b0) begin bad++; $display("FAIL reset_err got=%b%b exp=00", b0.err_over, b0.err_under); end
    total++; if (b1.spaces !== 7'd5) begin bad++; $display("FAIL reset_spaces_cap5 got=%0d exp=5", b1.spaces); end
  endtask

  task automatic test_pulses;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      b0.car_enter = 1'b1;
      @(posedge clk); #1;
      total++; if (b0.count !== 7'(i)) begin bad++; $display("FAIL enter_latency got=%0d exp=%0d", b0.count, i); end
      @(negedge clk);
      b0.car_enter = 1'b0;
      @(posedge clk); #1;
    end
    @(negedge clk);
    b0.car_exit = 1'b1;
    @(posedge clk); #1;
    total++; if (b0.count !== 7'd2) begin bad++; $display("FAIL exit_latency got=%0d exp=2", b0.count); end
    @(negedge clk);
    b0.car_exit = 1'b0;
    @(posedge clk); #1;
    total++; if (b0.spaces !== 7'd97) begin bad++; $display("FAIL pulses_spaces got=%0d exp=97", b0.spaces); end
    total++; if ({b0.bcd_tens, b0.bcd_ones} !== 8'h02) begin bad++; $display("FAIL pulses_bcd got=%0d/%0d exp=0/2", b0.bcd_tens, b0.bcd_ones); end
    total++; if (b0.empty !== 1'b0) begin bad++; $display("FAIL pulses_empty got=%b exp=0", b0.empty); end
  endtask

  task automatic test_held;
    for (int i = 0; i < 5; i++) pulse0(1'b1, 1'b0, 1'b0);
    total++; if (b0.count !== 7'd7) begin bad++; $display("FAIL held_pre got=%0d exp=7", b0.count); end
    @(negedge clk);
    b0.car_enter = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if (b0.count !== 7'd8) begin bad++; $display("FAIL held_once cyc=%0d got=%0d exp=8", i, b0.count); end
    end
    @(negedge clk);
    b0.car_enter = 1'b0;
    @(posedge clk); #1;
    pulse0(1'b1, 1'b1, 1'b0);
    total++; if (b0.count !== 7'd8) begin bad++; $display("FAIL both_mid got=%0d exp=8", b0.count); end
    total++; if ({b0.bcd_tens, b0.bcd_ones} !== 8'h08) begin bad++; $display("FAIL both_mid_bcd got=%0d/%0d exp=0/8", b0.bcd_tens, b0.bcd_ones); end
  endtask

  task automatic test_underflow;
    pulse0(1'b0, 1'b0, 1'b1);
    total++; if (b0.count !== 7'd0 || b0.empty !== 1'b1) begin bad++; $display("FAIL clr_count got=%0d empty=%b exp=0 1", b0.count, b0.empty); end
    pulse0(1'b1, 1'b1, 1'b0);
    total++; if (b0.count !== 7'd0 || b0.err_under !== 1'b0) begin bad++; $display("FAIL both_at_zero got=%0d eu=%b exp=0 0", b0.count, b0.err_under); end
    pulse0(1'b0, 1'b1, 1'b0);
    total++; if (b0.count !== 7'd0) begin bad++; $display("FAIL under_nowrap got=%0d exp=0", b0.count); end
    total++; if (b0.err_under !== 1'b1 || b0.empty !== 1'b1) begin bad++; $display("FAIL under_flag got eu=%b empty=%b exp=1 1", b0.err_under, b0.empty); end
    for (int i = 0; i < 12; i++) pulse0(1'b1, 1'b0, 1'b0);
    total++; if (b0.count !== 7'd12 || b0.spaces !== 7'd87) begin bad++; $display("FAIL twelve got=%0d spaces=%0d exp=12 87", b0.count, b0.spaces); end
    total++; if ({b0.bcd_tens, b0.bcd_ones} !== 8'h12) begin bad++; $display("FAIL twelve_bcd got=%0d/%0d exp=1/2", b0.bcd_tens, b0.bcd_ones); end
    total++; if (b0.err_under !== 1'b1) begin bad++; $display("FAIL under_sticky got=%b exp=1", b0.err_under); end
  endtask

  task automatic test_clr_event;
    @(negedge clk);
    b0.car_enter = 1'b1; b0.clr = 1'b1;
    @(posedge clk); #1;
    total++; if (b0.count !== 7'd0) begin bad++; $display("FAIL clr_wins got=%0d exp=0", b0.count); end
    total++; if (b0.err_over !== 1'b0 || b0.err_under !== 1'b0) begin bad++; $display("FAIL clr_errs got=%b%b exp=00", b0.err_over, b0.err_under); end
    @(negedge clk);
    b0.clr = 1'b0;
    @(posedge clk); #1;
    // Enter stayed high across clr, so its history register blocks a new event.
    total++; if (b0.count !== 7'd0) begin bad++; $display("FAIL clr_keeps_hist got=%0d exp=0", b0.count); end
    @(negedge clk);
    b0.car_enter = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 3; i++) pulse0(1'b1, 1'b0, 1'b0);
    total++; if (b0.count !== 7'd3) begin bad++; $display("FAIL pre_reset got=%0d exp=3", b0.count); end
    #2;
    reset_n = 1'b0;
    b0.car_enter = 1'b1;
    #1;
    total++; if (b0.count !== 7'd0 || b0.empty !== 1'b1 || b0.spaces !== 7'd99) begin bad++; $display("FAIL async_reset got=%0d empty=%b spaces=%0d exp=0 1 99", b0.count, b0.empty, b0.spaces); end
    @(posedge clk); #1;
    total++; if (b0.count !== 7'd0) begin bad++; $display("FAIL reset_discard got=%0d exp=0", b0.count); end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    total++; if (b0.count !== 7'd1) begin bad++; $display("FAIL first_edge got=%0d exp=1", b0.count); end
    @(posedge clk); #1;
    total++; if (b0.count !== 7'd1) begin bad++; $display("FAIL first_edge_hold got=%0d exp=1", b0.count); end
    @(negedge clk);
    b0.car_enter = 1'b0;
  endtask

  task automatic test_capacity;
    for (int i = 0; i < 5; i++) pulse1(1'b1, 1'b0);
    total++; if (b1.count !== 7'd5 || b1.full !== 1'b1 || b1.spaces !== 7'd0) begin bad++; $display("FAIL cap_full got=%0d full=%b spaces=%0d exp=5 1 0", b1.count, b1.full, b1.spaces); end
    total++; if (b1.err_over !== 1'b0) begin bad++; $display("FAIL cap_no_err_yet got=%b exp=0", b1.err_over); end
    pulse1(1'b1, 1'b1);
    total++; if (b1.count !== 7'd5 || b1.err_over !== 1'b0) begin bad++; $display("FAIL both_at_full got=%0d eo=%b exp=5 0", b1.count, b1.err_over); end
    pulse1(1'b1, 1'b0);
    total++; if (b1.count !== 7'd5 || b1.err_over !== 1'b1) begin bad++; $display("FAIL over got=%0d eo=%b exp=5 1", b1.count, b1.err_over); end
    pulse1(1'b0, 1'b1);
    total++; if (b1.count !== 7'd4 || b1.full !== 1'b0 || b1.spaces !== 7'd1) begin bad++; $display("FAIL after_exit got=%0d full=%b spaces=%0d exp=4 0 1", b1.count, b1.full, b1.spaces); end
    total++; if (b1.err_over !== 1'b1) begin bad++; $display("FAIL over_sticky got=%b exp=1", b1.err_over); end
  endtask

  initial begin
    b0.car_enter = 1'b0; b0.car_exit = 1'b0; b0.clr = 1'b0;
    b1.car_enter = 1'b0; b1.car_exit = 1'b0; b1.clr = 1'b0;
    test_reset();
    test_pulses();
    test_held();
    test_underflow();
    test_clr_event();
    test_async_reset();
    test_capacity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/occupancy_counter.md
OCCUPANCY_COUNTER -- requirements
Module: occupancy_counter

Interface
REQ-001 Parameter CAPACITY, default 99, meaning maximum number of cars the lot holds; legal range 1..99.
REQ-002 clk  input  1  rising-edge system clock, shared with the entry/exit detector FSM.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 car_enter  input  1  car-entered pulse from the detector FSM, synchronous to clk.
REQ-005 car_exit  input  1  car-exited pulse from the detector FSM, synchronous to clk.
REQ-006 clr  input  1  synchronous clear of count and error flags.
REQ-007 count  output  7  current occupancy, binary, 0..CAPACITY.
REQ-008 spaces  output  7  free spaces, equal to CAPACITY - count.
REQ-009 bcd_tens  output  4  tens digit of count, BCD.
REQ-010 bcd_ones  output  4  ones digit of count, BCD.
REQ-011 full  output  1  high when count == CAPACITY.
REQ-012 empty  output  1  high when count == 0.
REQ-013 err_over  output  1  sticky flag: an entry was seen while full.
REQ-014 err_under  output  1  sticky flag: an exit was seen while empty.

Function
REQ-015 All outputs SHALL be registered; none SHALL be driven combinationally from inputs.
REQ-016 Block SHALL hold one-cycle history registers enter_d, exit_d of car_enter and car_exit.
REQ-017 Events SHALL be rising edges only: ev_in = car_enter & ~enter_d; ev_out = car_exit & ~exit_d.
- An input held high for N cycles yields exactly one event.
REQ-018 Latency SHALL be one clock: an event in cycle N is reflected on every output from cycle N+1.
REQ-019 Priority per clock edge SHALL be: clr > (ev_in & ev_out) > ev_in alone / ev_out alone.
REQ-020 clr SHALL force count = 0, err_over = 0, err_under = 0, and discard any event in the same cycle.
- clr SHALL NOT clear enter_d or exit_d.
REQ-021 ev_in & ev_out together SHALL leave count unchanged and SHALL set no error, including at count 0 and at CAPACITY.
REQ-022 ev_in alone with count < CAPACITY SHALL increment count by 1.
REQ-023 ev_in alone with count == CAPACITY SHALL hold count (no wrap) and set err_over.
REQ-024 ev_out alone with count > 0 SHALL decrement count by 1.
REQ-025 ev_out alone with count == 0 SHALL hold count (no wrap to 127) and set err_under.
REQ-026 err_over and err_under SHALL remain set until clr or reset.
REQ-027 full, empty, spaces, bcd_tens and bcd_ones SHALL be computed from the next-count value and registered alongside count, so they are consistent with count in every cycle.
REQ-028 BCD conversion SHALL satisfy count = 10*bcd_tens + bcd_ones, with each digit 0..9.
REQ-029 Internal arithmetic SHALL be 7-bit unsigned; the saturation checks SHALL precede the add and subtract.

Reset
REQ-030 reset_n low SHALL immediately, without waiting for clk, force the following values:
- count = 0, spaces = CAPACITY, bcd_tens = 0, bcd_ones = 0
- full = 0 (1 if CAPACITY = 0 is ever permitted; it is not), empty = 1
- err_over = 0, err_under = 0, enter_d = 0, exit_d = 0
REQ-031 Reset asserted mid-operation SHALL discard any in-flight event.
REQ-032 The first clock edge after reset_n deasserts SHALL process inputs normally.
- A car_enter already high at that edge counts as one event.

Verification
REQ-033 Reset, then idle 10 cycles -> count 0, spaces 99, empty 1, full 0, bcd 0/0, both errors 0.
REQ-034 Three 1-cycle car_enter pulses then one car_exit pulse -> count 2, spaces 97, bcd 0/2, each change visible one cycle after its pulse.
REQ-035 car_enter held high 5 cycles, then car_enter and car_exit pulsed in the same cycle at count 7 -> count 8, then remains 8.
REQ-036 CAPACITY=5, six enter pulses, then one exit pulse:
- after six enters -> count 5, full 1, spaces 0, err_over 1
- after the exit -> count 4, full 0, err_over still 1
REQ-037 Exit pulse at count 0 -> count 0, err_under 1, empty 1; then 12 enters -> bcd 1/2.
REQ-038 clr coincident with an enter pulse at count 12 -> count 0, both errors 0.
- Then reset_n pulsed low between clock edges at count 3 -> count 0 before the next edge.
